ps2_key_sequencer: RTL
======================

// Module: ps2_key_sequencer
// PURPOSE
//  Controller downstream of the PS/2 byte receiver. Gates the receiver via rx_en and
//  consumes its rx_done_tick/byte stream. Folds E0 (extended) and F0 (break) prefixes
//  into single key events. Buffers events in a small FIFO with valid/ready output.
//  Sits between the PS/2 front end and the application logic (display/UART/game FSM).
// PARAMETERS
//  FIFO_DEPTH      4       event FIFO entries; power of two, >= 2
//  TIMEOUT_CYCLES  100000  max clk cycles between bytes of one sequence (PS2_TIMEOUT_EN only)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  rx_done_tick in   1  one-cycle strobe from receiver: rx_data valid this cycle
//  rx_data      in   8  received scan-code byte
//  rx_en        out  1  receiver enable; 1 = receiver may start a new frame
//  ev_valid     out  1  FIFO head holds an event
//  ev_ready     in   1  consumer accepts head when ev_valid & ev_ready
//  ev_code      out  8  scan code of head event, prefixes stripped
//  ev_ext       out  1  head event had E0 prefix
//  ev_break     out  1  head event is a release (F0 prefix)
//  overflow     out  1  sticky: an event was dropped because the FIFO was full
//  timeout_err  out  1  one-cycle pulse: partial sequence aborted (0 without macro)
// BEHAVIOUR
//  - Interface: one clock, clk; reset is asynchronous and active-high, port reset.
//  - Reset: FSM=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0,
//    overflow=0, timeout_err=0, rx_en=1.
//  - Prefix FSM; advances only in cycles with rx_done_tick=1:
//    IDLE   : E0->EXT; F0->BRK; other byte b -> push {ext=0,brk=0,b}, stay IDLE
//    EXT    : F0->EXTBRK; E0->stay EXT; other b -> push {1,0,b}, ->IDLE
//    BRK    : E0->EXT (F0 prefix discarded); F0->stay BRK; other b -> push {0,1,b}, ->IDLE
//    EXTBRK : E0/F0 -> stay EXTBRK; other b -> push {1,1,b}, ->IDLE
//    E1 (Pause) and all other bytes are ordinary codes; no Pause special handling.
//  - Latency: push in cycle N -> entry visible at head in N+1; empty FIFO gives
//    ev_valid=1 in N+1. FIFO is first-word-fall-through; ev_* valid whenever ev_valid.
//  - Pop when ev_valid & ev_ready; head advances next cycle. ev_* hold while stalled.
//  - Push while full with no pop same cycle: event dropped, overflow<=1 until reset.
//  - Push and pop same cycle when full: both performed, no overflow, count unchanged.
//  - Push and pop same cycle when count=1: new entry becomes head, ev_valid stays 1.
//  - rx_en = (count < FIFO_DEPTH); combinational from registered count. A frame already
//    in flight when rx_en falls still completes; its byte follows the push rules above.
//  - FSM state is not affected by FIFO fullness; a dropped event still returns to IDLE.
//  - Reset mid-sequence or mid-stall: all state cleared at once; pending events lost.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined: cycle counter cleared on every rx_done_tick and in IDLE;
//    in EXT/BRK/EXTBRK, on reaching TIMEOUT_CYCLES-1 with no byte, FSM->IDLE, prefix
//    discarded, timeout_err=1 for exactly that cycle. A byte arriving in that same
//    cycle takes priority: no timeout, normal transition.
//  Not defined: no counter; prefixes persist indefinitely; timeout_err tied 0;
//    TIMEOUT_CYCLES ignored.
// STRUCTURE
//  ps2_pkg: localparams PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0; FSM state encoding
//    (IDLE/EXT/BRK/EXTBRK, 2 bits); event word layout {ext,brk,code[7:0]} = 10 bits.
//  Sub-module ps2_event_fifo: generic FWFT sync FIFO (WIDTH, DEPTH), count output,
//    async active-high reset; prefix FSM, rx_en, overflow, timeout stay in top level.
// TESTING
//  1 byte 1C, ev_ready=1 -> one event {code=1C,ext=0,brk=0}, ev_valid high 1 cycle
//  2 bytes F0,1C -> single event {1C,ext=0,brk=1}; no event for the F0 byte
//  3 bytes E0,F0,75 -> single event {75,ext=1,brk=1}; then E0,75 -> {75,ext=1,brk=0}
//  4 ev_ready=0, 5 bytes 1C..20 (DEPTH=4) -> rx_en=0 after 4th, 5th dropped, overflow=1;
//    then ev_ready=1 -> codes 1C,1D,1E,1F in order, rx_en back to 1, overflow stays 1
//  5 FIFO full + push and pop same cycle -> overflow stays 0, order preserved
//  6 PS2_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte E0 then 20 idle cycles -> timeout_err
//    pulse 16 cycles after E0; next byte 1C -> {1C,ext=0}; reset asserted mid-EXT -> IDLE

Source files
------------

// File: rtl/ps2_key_sequencer_pkg.sv
// Shared types for the PS/2 key sequencer: prefix bytes, prefix FSM encoding
// and the 10-bit event word {ext, brk, code}.
package ps2_key_sequencer_pkg;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXT    = 2'd1,
      ST_BRK    = 2'd2,
      ST_EXTBRK = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   localparam int PS2_EVENT_W = $bits(ps2_event_t);

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_EXT_PREFIX) || (b == PS2_BRK_PREFIX);
   endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Receiver-side and event-side signals of the key sequencer.
// master: the sequencer itself; slave: the environment (receiver + consumer).
interface ps2_key_sequencer_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       overflow;
   logic       timeout_err;

   modport master (
      input  rx_done_tick, rx_data, ev_ready,
      output rx_en, ev_valid, ev_code, ev_ext, ev_break, overflow, timeout_err
   );

   modport slave (
      output rx_done_tick, rx_data, ev_ready,
      input  rx_en, ev_valid, ev_code, ev_ext, ev_break, overflow, timeout_err
   );
endinterface

// File: rtl/ps2_key_sequencer_event_fifo.sv
// ps2_event_fifo: generic first-word-fall-through synchronous FIFO.
// A push while full is accepted only when a pop happens in the same cycle.
// dout reads zero while empty so the event outputs are clean after reset.
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             pop_ok, push_ok;

   assign valid   = (count != '0);
   assign pop_ok  = pop & valid;
   assign push_ok = push & ((count < CW'(DEPTH)) | pop_ok);
   assign dout    = valid ? mem[rd_ptr] : '0;

   // storage write; no reset needed, reads are gated by valid
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: folds E0/F0 prefixes into single key events and buffers
// them in an event FIFO with valid/ready output.
// Optional feature macro PS2_TIMEOUT_EN: abort a partial prefix sequence after
// TIMEOUT_CYCLES-1 idle cycles (TIMEOUT_CYCLES >= 2).
module ps2_key_sequencer
   import ps2_key_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   ps2_key_sequencer_if.master  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   ps2_state_t      state, state_nxt;
   ps2_event_t      push_ev, head_ev;
   logic            push, pop, full, head_vld, tmo_hit, ovf_q;
   logic [CW-1:0]   count;

`ifdef PS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;

   // idle-cycle counter while a prefix is pending
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                             tmo_cnt <= '0;
      else if (bus.rx_done_tick || state == ST_IDLE || tmo_hit) tmo_cnt <= '0;
      else                                                   tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (state != ST_IDLE) && !bus.rx_done_tick &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // parameter sanity marker; the timeout length is unused in this build
   if (TIMEOUT_CYCLES < 2 || FIFO_DEPTH < 2) begin : g_cfg_out_of_range
   end
   assign tmo_hit = 1'b0;
`endif

   // prefix FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // prefix FSM next state; a byte in the timeout cycle wins over the timeout
   always_comb begin
      state_nxt = state;
      if (bus.rx_done_tick) begin
         if (bus.rx_data == PS2_EXT_PREFIX)
            state_nxt = (state == ST_EXTBRK) ? ST_EXTBRK : ST_EXT;
         else if (bus.rx_data == PS2_BRK_PREFIX)
            state_nxt = (state == ST_IDLE || state == ST_BRK) ? ST_BRK : ST_EXTBRK;
         else
            state_nxt = ST_IDLE;
      end else if (tmo_hit) begin
         state_nxt = ST_IDLE;
      end
   end

   // event generation on any non-prefix byte, flags taken from current state
   always_comb begin
      push         = 1'b0;
      push_ev      = '0;
      push_ev.code = bus.rx_data;
      push_ev.ext  = (state == ST_EXT) || (state == ST_EXTBRK);
      push_ev.brk  = (state == ST_BRK) || (state == ST_EXTBRK);
      if (bus.rx_done_tick && !is_prefix(bus.rx_data)) push = 1'b1;
   end

   ps2_event_fifo #(.WIDTH(PS2_EVENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_ev),
      .pop   (pop),
      .dout  (head_ev),
      .valid (head_vld),
      .count (count)
   );

   assign full = (count == CW'(FIFO_DEPTH));
   assign pop  = head_vld & bus.ev_ready;

   // sticky flag: an event was dropped on a full FIFO with no pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  ovf_q <= 1'b0;
      else if (push & full & ~pop) ovf_q <= 1'b1;
   end

   assign bus.rx_en       = (count < CW'(FIFO_DEPTH));
   assign bus.ev_valid    = head_vld;
   assign bus.ev_code     = head_ev.code;
   assign bus.ev_ext      = head_ev.ext;
   assign bus.ev_break    = head_ev.brk;
   assign bus.overflow    = ovf_q;
   assign bus.timeout_err = tmo_hit;
endmodule
